// File: rtl/power_db.sv
// power_db: converts an unsigned power sample (re^2 + im^2) into dB.
// The result is 10*log10(power_in) in unsigned Q8.FRAC_BITS format.
// log2 is computed as an integer part (MSB position k) plus FRAC_BITS
// fractional bits, one per cycle, by repeated squaring of the normalised
// mantissa. The log2 value is then scaled by 10*log10(2).
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   power_in   unsigned power sample, 2*IN_WIDTH bits
//   valid_in   power_in qualifier, taken only while ready_out is high
//   ready_out  high while idle
//   db_out     Q8.FRAC_BITS result, held until the next valid_out
//   zero_out   set with valid_out when the sample was 0
//   valid_out  one-cycle result strobe, FRAC_BITS+2 edges after acceptance
//   drop_cnt   (POWER_DB_DROP_CNT_EN only) saturating count of cycles with
//              valid_in high while busy
//
// Optional feature macro: POWER_DB_DROP_CNT_EN
//
// state | meaning
// IDLE  | waiting for a sample, ready_out high
// NORM  | locate MSB, normalise mantissa to Q1.15
// ITER  | one squaring step per cycle, FRAC_BITS steps
// SCALE | multiply by 10*log10(2), publish result
module power_db #(
  parameter int IN_WIDTH  = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [2*IN_WIDTH-1:0]  power_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [8+FRAC_BITS-1:0] db_out,
  output logic                   zero_out,
  output logic                   valid_out
`ifdef POWER_DB_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt
`endif
);

  localparam int PW      = 2 * IN_WIDTH;
  localparam int KW      = $clog2(PW);
  localparam int CW      = $clog2(FRAC_BITS + 1);
  localparam int LW      = KW + FRAC_BITS;
  localparam int DW      = 8 + FRAC_BITS;
  localparam int PRODW   = LW + DW + 17;
  localparam int SCALE_K = 49321;  // 10*log10(2) in Q2.14
  localparam int ROUND_K = 8192;   // half LSB before the >>14

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_SCALE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   sample_q;
  logic [KW-1:0]   k_q;
  logic [15:0]     m_q;
  logic [FRAC_BITS-1:0] frac_q;
  logic [CW-1:0]   cnt_q;
  logic            zero_q;
  logic [DW-1:0]   db_q;
  logic            zero_out_q;
  logic            valid_q;
  logic            accept;

  logic [KW-1:0]   k_norm;
  logic [KW-1:0]   sh;
  logic [PW-1:0]   shifted;
  logic [15:0]     m_norm;
  logic [31:0]     sq;
  logic [LW-1:0]   l_val;
  logic [PRODW-1:0] prod;
  logic [DW-1:0]   db_scaled;
  logic            unused_bits;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A zero sample skips the squaring but still waits out
  // the same number of cycles in SCALE so result latency is fixed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (valid_in) state_d = S_NORM;
      S_NORM:  state_d = (sample_q == '0) ? S_SCALE : S_ITER;
      S_ITER:  if (cnt_q == '0) state_d = S_SCALE;
      S_SCALE: if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_out = (state_q == S_IDLE);
    accept    = ready_out && valid_in;
    db_out    = db_q;
    zero_out  = zero_out_q;
    valid_out = valid_q;
  end

  // MSB locator and mantissa normalisation
  always_comb begin
    k_norm = '0;
    for (int i = 0; i < PW; i++) begin
      if (sample_q[i]) k_norm = KW'(i);
    end
    sh      = KW'(PW - 1) - k_norm;
    shifted = sample_q << sh;
    m_norm  = shifted[PW-1 -: 16];
  end

  // The only 16x16 multiplier for the squaring loop
  assign sq = {16'b0, m_q} * {16'b0, m_q};

  assign l_val     = {k_q, frac_q};
  assign prod      = PRODW'(l_val) * PRODW'(SCALE_K) + PRODW'(ROUND_K);
  assign db_scaled = prod[DW+13:14];

  assign unused_bits = ^{sq[14:0], prod[13:0], prod[PRODW-1:DW+14], shifted[PW-17:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_q   <= '0;
      k_q        <= '0;
      m_q        <= '0;
      frac_q     <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      db_q       <= '0;
      zero_out_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) sample_q <= power_in;
        end
        S_NORM: begin
          k_q    <= k_norm;
          m_q    <= m_norm;
          frac_q <= '0;
          zero_q <= (sample_q == '0);
          cnt_q  <= (sample_q == '0) ? CW'(FRAC_BITS) : CW'(FRAC_BITS - 1);
        end
        S_ITER: begin
          // p >= 2.0 means the next log2 bit is 1; renormalise into [1,2)
          m_q    <= sq[31] ? sq[31:16] : sq[30:15];
          frac_q <= FRAC_BITS'({frac_q, sq[31]});
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        S_SCALE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            valid_q    <= 1'b1;
            zero_out_q <= zero_q;
            db_q       <= zero_q ? '0 : db_scaled;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef POWER_DB_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                        drop_q <= '0;
    else if (valid_in && !ready_out && drop_q != '1)  drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`endif

endmodule
